// File: rtl/id_ex_forward_stage.sv
// -----------------------------------------------------------------------------
// id_ex_forward_stage
//
// This module is the ID/EX pipeline boundary, driven by the decisions of the
// hazard/forwarding unit.
//   * Each ID operand (PA, PB, PD) is chosen by a combinational 4:1 mux. The
//     sources are the register file or the EX, MEM or WB result bus.
//   * The chosen operands and the decoded control word are registered into
//     the EX stage.
//   * A load-use stall (nop low) or a branch flush loads a bubble into EX.
//   * The destination tag and RF-write enable are carried through EX, MEM and
//     WB. These registered tags feed the hazard unit's comparators.
//
// Optional feature: define STALL_COUNT_EN to build a 16-bit saturating
// counter of load-use bubbles. Without that macro, bubble_count is tied to 0
// and no counter flops exist.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   fwd_pa/pb/pd [1:0]         operand source: 00 RF, 01 EX, 10 MEM, 11 WB
//   nop                        active-low bubble request (load-use stall)
//   flush                      active-high branch flush
//   rf_pa/pb/pd                register file read data
//   ex/mem/wb_result           forwarding buses
//   id_rd, id_ctrl             ID destination register and decoded control
//   id_rf_enable, id_load_instr, id_valid   ID-stage flags
//   ex_pa/pb/pd, ex_ctrl       registered EX operands and control
//   ex/mem/wb_rd               destination tag per stage
//   ex/mem/wb_rf_enable        RF-write flag per stage
//   ex_load_instr, ex_valid    EX flags
//   bubble_count               load-use bubble counter (0 unless enabled)
// -----------------------------------------------------------------------------
module id_ex_forward_stage #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        fwd_pa,
    input  logic [1:0]        fwd_pb,
    input  logic [1:0]        fwd_pd,
    input  logic              nop,
    input  logic              flush,
    input  logic [DATA_W-1:0] rf_pa,
    input  logic [DATA_W-1:0] rf_pb,
    input  logic [DATA_W-1:0] rf_pd,
    input  logic [DATA_W-1:0] ex_result,
    input  logic [DATA_W-1:0] mem_result,
    input  logic [DATA_W-1:0] wb_result,
    input  logic [3:0]        id_rd,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              id_rf_enable,
    input  logic              id_load_instr,
    input  logic              id_valid,
    output logic [DATA_W-1:0] ex_pa,
    output logic [DATA_W-1:0] ex_pb,
    output logic [DATA_W-1:0] ex_pd,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [3:0]        ex_rd,
    output logic [3:0]        mem_rd,
    output logic [3:0]        wb_rd,
    output logic              ex_rf_enable,
    output logic              mem_rf_enable,
    output logic              wb_rf_enable,
    output logic              ex_load_instr,
    output logic              ex_valid,
    output logic [15:0]       bubble_count
);

    localparam int NUM_OPS = 3;

    // Operands are packed so that one generate loop builds all three muxes.
    logic [NUM_OPS-1:0][1:0]        sel_arr;
    logic [NUM_OPS-1:0][DATA_W-1:0] rf_arr;
    logic [NUM_OPS-1:0][DATA_W-1:0] mux_arr;
    logic                           bubble;

    assign sel_arr[0] = fwd_pa;
    assign sel_arr[1] = fwd_pb;
    assign sel_arr[2] = fwd_pd;
    assign rf_arr[0]  = rf_pa;
    assign rf_arr[1]  = rf_pb;
    assign rf_arr[2]  = rf_pd;

    // These muxes are purely combinational and feed the EX D-inputs
    // directly, so a forwarding decision takes effect in the same cycle.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_OPS; gi++) begin : g_op_mux
            assign mux_arr[gi] = sel_arr[gi][1]
                               ? (sel_arr[gi][0] ? wb_result : mem_result)
                               : (sel_arr[gi][0] ? ex_result : rf_arr[gi]);
        end
    endgenerate

    // A load-use stall and a flush in the same cycle still give only one
    // bubble.
    assign bubble = ~nop | flush;

    // The EX stage never holds: each edge loads either a new instruction or
    // a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_pa         <= '0;
            ex_pb         <= '0;
            ex_pd         <= '0;
            ex_ctrl       <= '0;
            ex_rd         <= '0;
            ex_rf_enable  <= 1'b0;
            ex_load_instr <= 1'b0;
            ex_valid      <= 1'b0;
        end else if (bubble) begin
            ex_pa         <= '0;
            ex_pb         <= '0;
            ex_pd         <= '0;
            ex_ctrl       <= '0;
            ex_rd         <= '0;
            ex_rf_enable  <= 1'b0;
            ex_load_instr <= 1'b0;
            ex_valid      <= 1'b0;
        end else begin
            ex_pa         <= mux_arr[0];
            ex_pb         <= mux_arr[1];
            ex_pd         <= mux_arr[2];
            ex_ctrl       <= id_ctrl;
            ex_rd         <= id_rd;
            ex_rf_enable  <= id_rf_enable;
            ex_load_instr <= id_load_instr;
            ex_valid      <= id_valid;
        end
    end

    // MEM and WB tags shift on every edge. Instructions that are already in
    // flight must retire even while ID is stalled or flushed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_rd        <= '0;
            mem_rf_enable <= 1'b0;
            wb_rd         <= '0;
            wb_rf_enable  <= 1'b0;
        end else begin
            mem_rd        <= ex_rd;
            mem_rf_enable <= ex_rf_enable;
            wb_rd         <= mem_rd;
            wb_rf_enable  <= mem_rf_enable;
        end
    end

`ifdef STALL_COUNT_EN
    // The counter tracks load-use stalls only. A flush alone does not count,
    // but nop low together with flush does. The counter saturates rather
    // than wraps.
    logic [15:0] bubble_count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_count_reg <= '0;
        end else if (!nop && (bubble_count_reg != 16'hFFFF)) begin
            bubble_count_reg <= bubble_count_reg + 16'd1;
        end
    end

    assign bubble_count = bubble_count_reg;
`else
    assign bubble_count = 16'h0000;
`endif

endmodule

// File: tb/tb_id_ex_forward_stage.sv
// -----------------------------------------------------------------------------
// Self-checking bench for id_ex_forward_stage.
// Vectors in a table are driven one per cycle. On each drive, the expected EX
// state is pushed to a queue. After the edge it is popped and compared. A
// small tag-shift model provides the expected MEM and WB tags, and a counter
// model provides the expected bubble_count. Hand-written sequences cover the
// mid-stream asynchronous reset and, with STALL_COUNT_EN, counter
// saturation.
// -----------------------------------------------------------------------------
module tb_id_ex_forward_stage;

    localparam int DW = 32;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    fwd_pa, fwd_pb, fwd_pd;
    logic          nop, flush;
    logic [DW-1:0] rf_pa, rf_pb, rf_pd;
    logic [DW-1:0] ex_result, mem_result, wb_result;
    logic [3:0]    id_rd;
    logic [CW-1:0] id_ctrl;
    logic          id_rf_enable, id_load_instr, id_valid;
    logic [DW-1:0] ex_pa, ex_pb, ex_pd;
    logic [CW-1:0] ex_ctrl;
    logic [3:0]    ex_rd, mem_rd, wb_rd;
    logic          ex_rf_enable, mem_rf_enable, wb_rf_enable;
    logic          ex_load_instr, ex_valid;
    logic [15:0]   bubble_count;

    always #5 clk = ~clk;

    id_ex_forward_stage #(.DATA_W(DW), .CTRL_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .fwd_pa(fwd_pa), .fwd_pb(fwd_pb), .fwd_pd(fwd_pd),
        .nop(nop), .flush(flush),
        .rf_pa(rf_pa), .rf_pb(rf_pb), .rf_pd(rf_pd),
        .ex_result(ex_result), .mem_result(mem_result), .wb_result(wb_result),
        .id_rd(id_rd), .id_ctrl(id_ctrl),
        .id_rf_enable(id_rf_enable), .id_load_instr(id_load_instr), .id_valid(id_valid),
        .ex_pa(ex_pa), .ex_pb(ex_pb), .ex_pd(ex_pd), .ex_ctrl(ex_ctrl),
        .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .ex_rf_enable(ex_rf_enable), .mem_rf_enable(mem_rf_enable), .wb_rf_enable(wb_rf_enable),
        .ex_load_instr(ex_load_instr), .ex_valid(ex_valid),
        .bubble_count(bubble_count)
    );

    typedef struct {
        logic [1:0]    f_pa, f_pb, f_pd;
        logic          v_nop, v_flush;
        logic [3:0]    rd;
        logic [CW-1:0] ctrl;
        logic          rfen, ld, vld;
        logic [DW-1:0] e_pa, e_pb, e_pd;
    } vec_t;

    typedef struct {
        logic [DW-1:0] pa, pb, pd;
        logic [CW-1:0] ctrl;
        logic [3:0]    rd;
        logic          rfen, ld, vld;
    } exp_t;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb_q[$];
    vec_t vecs[12];

    // Model state for the tags and the counter.
    logic [3:0]  m_ex_rd, m_mem_rd, m_wb_rd;
    logic        m_ex_en, m_mem_en, m_wb_en;
    logic [15:0] m_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ex_rd = 0; m_mem_rd = 0; m_wb_rd = 0;
        m_ex_en = 0; m_mem_en = 0; m_wb_en = 0;
        m_cnt   = 0;
    endtask

    // Drive one vector, push the expected EX state, wait one edge, then pop
    // the entry and compare every output.
    task automatic step(input int idx, input vec_t v);
        exp_t e, got;
        logic bub;
        fwd_pa = v.f_pa; fwd_pb = v.f_pb; fwd_pd = v.f_pd;
        nop = v.v_nop; flush = v.v_flush;
        id_rd = v.rd; id_ctrl = v.ctrl;
        id_rf_enable = v.rfen; id_load_instr = v.ld; id_valid = v.vld;
        bub = !v.v_nop || v.v_flush;
        e.pa   = v.e_pa; e.pb = v.e_pb; e.pd = v.e_pd;
        e.ctrl = bub ? '0 : v.ctrl;
        e.rd   = bub ? '0 : v.rd;
        e.rfen = bub ? 1'b0 : v.rfen;
        e.ld   = bub ? 1'b0 : v.ld;
        e.vld  = bub ? 1'b0 : v.vld;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        m_wb_rd = m_mem_rd; m_wb_en = m_mem_en;
        m_mem_rd = m_ex_rd; m_mem_en = m_ex_en;
        m_ex_rd = got.rd;   m_ex_en = got.rfen;
`ifdef STALL_COUNT_EN
        if (!v.v_nop && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
`endif
        $display("txn %0d: fwd=%0d/%0d/%0d nop=%0b flush=%0b -> ex_pa=%0h ex_pb=%0h ex_pd=%0h ex_rd=%0d mem_rd=%0d wb_rd=%0d cnt=%0d",
                 idx, v.f_pa, v.f_pb, v.f_pd, v.v_nop, v.v_flush, ex_pa, ex_pb, ex_pd,
                 ex_rd, mem_rd, wb_rd, bubble_count);
        chk("ex_pa", 64'(ex_pa), 64'(got.pa));
        chk("ex_pb", 64'(ex_pb), 64'(got.pb));
        chk("ex_pd", 64'(ex_pd), 64'(got.pd));
        chk("ex_ctrl", 64'(ex_ctrl), 64'(got.ctrl));
        chk("ex_rd", 64'(ex_rd), 64'(got.rd));
        chk("ex_rf_enable", 64'(ex_rf_enable), 64'(got.rfen));
        chk("ex_load_instr", 64'(ex_load_instr), 64'(got.ld));
        chk("ex_valid", 64'(ex_valid), 64'(got.vld));
        chk("mem_rd", 64'(mem_rd), 64'(m_mem_rd));
        chk("mem_rf_enable", 64'(mem_rf_enable), 64'(m_mem_en));
        chk("wb_rd", 64'(wb_rd), 64'(m_wb_rd));
        chk("wb_rf_enable", 64'(wb_rf_enable), 64'(m_wb_en));
        chk("bubble_count", 64'(bubble_count), 64'(m_cnt));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ex_pa"}, 64'(ex_pa), 64'd0);
        chk({tag, "_ex_pb"}, 64'(ex_pb), 64'd0);
        chk({tag, "_ex_pd"}, 64'(ex_pd), 64'd0);
        chk({tag, "_ex_ctrl"}, 64'(ex_ctrl), 64'd0);
        chk({tag, "_ex_rd"}, 64'(ex_rd), 64'd0);
        chk({tag, "_mem_rd"}, 64'(mem_rd), 64'd0);
        chk({tag, "_wb_rd"}, 64'(wb_rd), 64'd0);
        chk({tag, "_flags"}, 64'({ex_rf_enable, mem_rf_enable, wb_rf_enable, ex_load_instr, ex_valid}), 64'd0);
        chk({tag, "_bubble_count"}, 64'(bubble_count), 64'd0);
    endtask

    initial begin
        // Fixed data sources make each mux selection distinguishable.
        rf_pa = 32'h11; rf_pb = 32'h51; rf_pd = 32'h61;
        ex_result = 32'h22; mem_result = 32'h33; wb_result = 32'h44;

        //          fpa   fpb   fpd   nop  fl    rd     ctrl   rfen  ld    vld   e_pa   e_pb   e_pd
        vecs[0]  = '{2'd0, 2'd0, 2'd0, 1'b1, 1'b0, 4'd5, 8'hA5, 1'b1, 1'b0, 1'b1, 32'h11, 32'h51, 32'h61};
        vecs[1]  = '{2'd1, 2'd1, 2'd1, 1'b1, 1'b0, 4'd0, 8'h01, 1'b0, 1'b0, 1'b1, 32'h22, 32'h22, 32'h22};
        vecs[2]  = '{2'd2, 2'd0, 2'd0, 1'b1, 1'b0, 4'd0, 8'h02, 1'b0, 1'b0, 1'b1, 32'h33, 32'h51, 32'h61};
        vecs[3]  = '{2'd3, 2'd2, 2'd3, 1'b1, 1'b0, 4'd0, 8'h03, 1'b0, 1'b0, 1'b1, 32'h44, 32'h33, 32'h44};
        vecs[4]  = '{2'd0, 2'd0, 2'd0, 1'b1, 1'b0, 4'd3, 8'h5A, 1'b1, 1'b1, 1'b1, 32'h11, 32'h51, 32'h61};
        vecs[5]  = '{2'd1, 2'd1, 2'd1, 1'b0, 1'b0, 4'd4, 8'h77, 1'b1, 1'b0, 1'b1, 32'h00, 32'h00, 32'h00};
        vecs[6]  = '{2'd1, 2'd0, 2'd2, 1'b1, 1'b0, 4'd4, 8'h77, 1'b1, 1'b0, 1'b1, 32'h22, 32'h51, 32'h33};
        vecs[7]  = '{2'd3, 2'd3, 2'd3, 1'b0, 1'b1, 4'd6, 8'h66, 1'b1, 1'b1, 1'b1, 32'h00, 32'h00, 32'h00};
        vecs[8]  = '{2'd2, 2'd3, 2'd1, 1'b1, 1'b0, 4'd9, 8'h99, 1'b1, 1'b0, 1'b1, 32'h33, 32'h44, 32'h22};
        vecs[9]  = '{2'd1, 2'd1, 2'd1, 1'b1, 1'b1, 4'd7, 8'h12, 1'b1, 1'b0, 1'b1, 32'h00, 32'h00, 32'h00};
        vecs[10] = '{2'd0, 2'd1, 2'd2, 1'b1, 1'b0, 4'd8, 8'h34, 1'b1, 1'b1, 1'b1, 32'h11, 32'h22, 32'h33};
        vecs[11] = '{2'd0, 2'd0, 2'd0, 1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h11, 32'h51, 32'h61};

        // Reset state, applied before any clock edge.
        rst_n = 1'b0;
        fwd_pa = 0; fwd_pb = 0; fwd_pd = 0; nop = 1'b1; flush = 1'b0;
        id_rd = 0; id_ctrl = 0; id_rf_enable = 0; id_load_instr = 0; id_valid = 0;
        model_reset();
        #3;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) step(i, vecs[i]);

        // Mid-stream reset: fill the pipe with valid instructions, then
        // assert rst_n between edges. All outputs must clear immediately.
        step(100, vecs[0]);
        step(101, vecs[10]);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step(102, vecs[8]);
        step(103, vecs[5]);

`ifdef STALL_COUNT_EN
        // Saturation: the counter stops at 0xFFFF and does not wrap.
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        nop = 1'b0; flush = 1'b0;
        repeat (65540) @(posedge clk);
        #1;
        chk("sat_bubble_count", 64'(bubble_count), 64'hFFFF);
        @(posedge clk);
        #1;
        chk("sat_hold", 64'(bubble_count), 64'hFFFF);
        nop = 1'b1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Guard against a hang: stop with a failure line if the run never ends.
    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
